// File: rtl/fetch_stage.sv
// RV32I instruction-fetch front end: owns pcF, one outstanding imem request,
// hold buffer for stalled decode, and the F/D pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        pred_taken,
  input  logic [31:0] pred_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] instF,
  output logic        instF_valid,
  output logic [31:0] instD,
  output logic [31:0] pcD,
  output logic        validD
);

  typedef enum logic [1:0] {
    ST_ISSUE,
    ST_WAIT,
    ST_FULL
  } state_t;

  state_t      r_state;
  state_t      w_state_n;
  logic [31:0] r_pcF;
  logic [31:0] w_pcF_n;
  logic [31:0] r_hold;
  logic [31:0] w_hold_n;
  logic        r_drop;
  logic        w_drop_n;
  logic [31:0] r_instD;
  logic [31:0] w_instD_n;
  logic [31:0] r_pcD;
  logic [31:0] w_pcD_n;
  logic        r_validD;
  logic        w_validD_n;

  logic        w_fresh;
  logic        w_full;
  logic [31:0] w_pc_adv;
  logic [31:0] w_redir_pc;
  logic        w_unused;

  assign w_unused = ^{redirect_pc[1:0], pred_pc[1:0]};

  assign w_fresh    = (r_state == ST_WAIT) && imem_rvalid && !r_drop;
  assign w_full     = (r_state == ST_FULL);
  assign w_redir_pc = {redirect_pc[31:2], 2'b00};
  assign w_pc_adv   = pred_taken ? {pred_pc[31:2], 2'b00}
                                 : r_pcF + 32'd4;

  assign imem_req  = !rst && (r_state == ST_ISSUE);
  assign imem_addr = r_pcF;

  always_comb begin
    instF       = NOP;
    instF_valid = 1'b0;
    unique case (1'b1)
      w_full: begin
        instF       = r_hold;
        instF_valid = 1'b1;
      end
      w_fresh: begin
        instF       = imem_rdata;
        instF_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_n  = r_state;
    w_pcF_n    = r_pcF;
    w_hold_n   = r_hold;
    w_drop_n   = r_drop;
    w_instD_n  = r_instD;
    w_pcD_n    = r_pcD;
    w_validD_n = r_validD;

    if (redirect_en) begin
      // Redirect beats stall and prediction; anything in F is now wrong-path.
      w_pcF_n    = w_redir_pc;
      w_hold_n   = NOP;
      w_instD_n  = NOP;
      w_validD_n = 1'b0;
      case (r_state)
        ST_ISSUE: begin
          w_drop_n  = 1'b1;
          w_state_n = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            w_drop_n  = 1'b0;
            w_state_n = ST_ISSUE;
          end else begin
            w_drop_n  = 1'b1;
          end
        end
        default: w_state_n = ST_ISSUE;
      endcase
    end else begin
      if (!stall && !instF_valid) begin
        w_instD_n  = NOP;
        w_validD_n = 1'b0;
      end
      case (r_state)
        ST_ISSUE: w_state_n = ST_WAIT;
        ST_WAIT: begin
          if (imem_rvalid && r_drop) begin
            w_drop_n  = 1'b0;
            w_state_n = ST_ISSUE;
          end else if (imem_rvalid) begin
            if (stall) begin
              w_hold_n  = imem_rdata;
              w_state_n = ST_FULL;
            end else begin
              w_instD_n  = imem_rdata;
              w_pcD_n    = r_pcF;
              w_validD_n = 1'b1;
              w_pcF_n    = w_pc_adv;
              w_state_n  = ST_ISSUE;
            end
          end
        end
        default: begin
          if (!stall) begin
            w_instD_n  = r_hold;
            w_pcD_n    = r_pcF;
            w_validD_n = 1'b1;
            w_pcF_n    = w_pc_adv;
            w_state_n  = ST_ISSUE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_ISSUE;
      r_pcF    <= RESET_PC;
      r_hold   <= NOP;
      r_drop   <= 1'b0;
      r_instD  <= NOP;
      r_pcD    <= 32'd0;
      r_validD <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_pcF    <= w_pcF_n;
      r_hold   <= w_hold_n;
      r_drop   <= w_drop_n;
      r_instD  <= w_instD_n;
      r_pcD    <= w_pcD_n;
      r_validD <= w_validD_n;
    end
  end

  assign instD  = r_instD;
  assign pcD    = r_pcD;
  assign validD = r_validD;

endmodule
